// File: rtl/arith_pkg.sv
// arith_pkg: shared opcode, operand-select and FSM state types for the arithmetic unit
package arith_pkg;
    typedef enum logic [1:0] {ADD, SUB, MUL, DIV} opcode_t;
    typedef enum logic [1:0] {M_REGB, M_MEM, M_IMM, M_ZERO} movi_t;
    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN} state_t;
    localparam int MUL_CNT_W = 4;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle, done pulses WIDTH cycles after start
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] q, d, rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_sh, diff;
    assign r_sh     = {rem, q[WIDTH-1]};
    assign diff     = r_sh - {1'b0, d};
    assign busy     = cnt != '0;
    assign quotient = q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q    <= '0;
            d    <= '0;
            rem  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q   <= dividend;
                d   <= divisor;
                rem <= '0;
                cnt <= CW'(WIDTH);
            end else if (busy) begin
                rem  <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                q    <= {q[WIDTH-2:0], ~diff[WIDTH]};
                cnt  <= cnt - 1'b1;
                done <= cnt == CW'(1);
            end
        end
    end
endmodule

// File: rtl/pipelined_arith_unit.sv
// pipelined_arith_unit: ADD/SUB/MUL/DIV with latched operands, READY back-pressure and sequential divider
module pipelined_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ACT,
    output logic             READY,
    input  logic [1:0]       OP_CODE,
    input  logic [1:0]       MOVI,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] REG_A,
    input  logic [WIDTH-1:0] REG_B,
    input  logic [WIDTH-1:0] MEM,
    input  logic [WIDTH-1:0] IMM,
    output logic [WIDTH-1:0] DATA,
    output logic             DATA_VALID,
    output logic             DIV_ZERO
);
    state_t                 state, state_nxt;
    opcode_t                op, op_q;
    movi_t                  movi;
    logic [WIDTH-1:0]       b_sel, a_q, b_q, a_mag, b_mag, quotient, div_res, res;
    logic [MUL_CNT_W-1:0]   cnt;
    logic                   accept, b_zero, pend, div0_q, neg_q, div_start, div_busy, div_done, div_fin, mul_fin;
    assign op        = opcode_t'(OP_CODE);
    assign movi      = movi_t'(MOVI);
    assign b_sel     = movi == M_REGB ? REG_B : movi == M_MEM ? MEM : movi == M_IMM ? IMM : '0;
    assign b_zero    = b_sel == '0;
    assign READY     = state == IDLE && !div_busy;
    assign accept    = ACT && READY;
    assign a_mag     = (SIGNED && REG_A[WIDTH-1]) ? -REG_A : REG_A;
    assign b_mag     = (SIGNED && b_sel[WIDTH-1]) ? -b_sel : b_sel;
    assign div_start = accept && op == DIV && !b_zero;
    assign div_res   = neg_q ? -quotient : quotient;
    assign div_fin   = state == DIV_RUN && div_done;
    assign mul_fin   = state == MUL_WAIT && cnt == MUL_CNT_W'(MUL_LATENCY - 1);
    always_comb res = op_q == ADD ? a_q + b_q : op_q == SUB ? a_q - b_q : op_q == MUL ? a_q * b_q : '0;
    seq_divider #(.WIDTH(WIDTH)) u_div (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = (accept && op == MUL && MUL_LATENCY > 1) ? MUL_WAIT : div_start ? DIV_RUN : IDLE;
            MUL_WAIT: state_nxt = mul_fin ? IDLE : MUL_WAIT;
            DIV_RUN:  state_nxt = div_done ? IDLE : DIV_RUN;
            default:  state_nxt = IDLE;
        endcase
    end
    // pend marks a result due on the next edge, computed from the captured operands
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q       <= ADD;
            a_q        <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            div0_q     <= 1'b0;
            pend       <= 1'b0;
            cnt        <= '0;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            DIV_ZERO   <= 1'b0;
        end else begin
            DATA_VALID <= pend || div_fin;
            DIV_ZERO   <= pend && div0_q;
            DATA       <= pend ? res : div_fin ? div_res : DATA;
            pend       <= mul_fin || (accept && (op == ADD || op == SUB || (op == DIV && b_zero)
                                                 || (op == MUL && MUL_LATENCY == 1)));
            cnt        <= state == MUL_WAIT ? cnt + 1'b1 : MUL_CNT_W'(1);
            if (accept) begin
                op_q   <= op;
                a_q    <= REG_A;
                b_q    <= b_sel;
                neg_q  <= SIGNED && (REG_A[WIDTH-1] ^ b_sel[WIDTH-1]);
                div0_q <= op == DIV && b_zero;
            end
        end
    end
endmodule
